sram_resp: RTL

Memory-side responder for the core's instruction/data ports: accepts one request at a time over a valid/ready request channel, models an SRAM with programmable access latency, and returns read data or a write acknowledgement over a valid/ready response channel. It is the target end of the handshake the multi-cycle IFU/LSU will drive, and replaces direct combinational DPI memory access in the top level.

---
 rtl/liang_pkg.sv | 15 +
 rtl/sram_array.sv | 31 +++
 rtl/sram_resp.sv | 135 +++++++++++++
 3 files changed

// File: rtl/liang_pkg.sv
// Shared core definitions: datapath width, memory map base, responder FSM states.
package liang_pkg;

  localparam int XLEN = 32;

  // Byte address of the first word of main memory, shared with the IFU/LSU.
  localparam logic [XLEN-1:0] MEM_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

endpackage

// File: rtl/sram_array.sv
// Single-port word storage: synchronous byte-strobed write, combinational read.
// Contents have no reset; they are initialised by a back-door load.
module sram_array
  import liang_pkg::*;
#(
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH),
  localparam int BYTES = XLEN / 8
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [AW-1:0]    index,
  input  logic [XLEN-1:0]  wdata,
  input  logic [BYTES-1:0] wstrb,
  output logic [XLEN-1:0]  rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Only strobed byte lanes of the addressed word are updated.
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/sram_resp.sv
// Memory-side responder: one request at a time over valid/ready, programmable
// access latency (optionally jittered by an LFSR), response over valid/ready.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready are
// both high. Once rsp_valid_o rises, it and rsp_rdata_o/rsp_err_o stay constant
// until that transfer; req_* inputs are only looked at while req_ready_o is high.
//
// Timing: an accepted request spends LATENCY + extra cycles in WAIT; the edge
// that leaves WAIT (counter at 0) performs the array access and registers the
// response, so rsp_valid_o rises LATENCY + extra edges after the accept edge.
module sram_resp
  import liang_pkg::*;
#(
  parameter logic [XLEN-1:0] ADDR_BASE = MEM_BASE,  // must be word aligned
  parameter int DEPTH    = 4096,
  parameter int LATENCY  = 1,
  parameter int RAND_DLY = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [XLEN-1:0]    req_addr_i,
  input  logic               req_wen_i,
  input  logic [XLEN-1:0]    req_wdata_i,
  input  logic [XLEN/8-1:0]  req_wstrb_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [XLEN-1:0]    rsp_rdata_o,
  output logic               rsp_err_o,
  output resp_state_e        dbg_state_o
);

  localparam int BYTES = XLEN / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);

  resp_state_e      state, state_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic [7:0]       lfsr;
  logic [XLEN-1:0]  addr_q, wdata_q, rdata_q;
  logic [BYTES-1:0] wstrb_q;
  logic             wen_q, err_q;
  logic             accept, access, addr_err, mem_we;
  logic [XLEN-1:0]  offset, mem_rdata;
  logic [AW-1:0]    index;

  assign accept = (state == IDLE) && req_valid_i;
  assign access = (state == WAIT) && (cnt == 5'd0);

  // Offset below the base wraps to a huge value, so one upper-bits test covers
  // both ends of the window; low offset bits equal address bits (aligned base).
  assign offset   = addr_q - ADDR_BASE;
  assign addr_err = (offset[XLEN-1:AW+BSH] != '0) || (offset[BSH-1:0] != '0);
  assign index    = offset[AW+BSH-1:BSH];
  assign mem_we   = access && wen_q && !addr_err;

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign dbg_state_o = state;

  // State and wait counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: load latency on accept, count down in WAIT, leave RESP on handshake.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid_i) begin
          state_nxt = WAIT;
          cnt_nxt   = 5'(LATENCY - 1) + ((RAND_DLY != 0) ? {3'b000, lfsr[1:0]} : 5'd0);
        end
      end
      WAIT: begin
        if (cnt == 5'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 5'd1;
      end
      RESP: begin
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the request on accept; register the response on the access edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i;
        wen_q   <= req_wen_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
      end
      if (access) begin
        err_q   <= addr_err;
        rdata_q <= (wen_q || addr_err) ? '0 : mem_rdata;
      end
    end
  end

  // Free-running delay jitter source, x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  sram_array #(.DEPTH(DEPTH)) u_array (
    .clk_i (clk_i),
    .we    (mem_we),
    .index (index),
    .wdata (wdata_q),
    .wstrb (wstrb_q),
    .rdata (mem_rdata)
  );

endmodule
